count_checker: RTL and testbench
================================

COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high (ports clk and rst).
REQ-002 Parameter WIDTH SHALL be provided: default 4; width of observed count, ldvalue and expected value.
REQ-003 Parameter ERR_W SHALL be provided: default 8; width of the error counter.
REQ-004 Parameter RESYNC_N SHALL be provided: default 3; consecutive mismatches that force a resync.
REQ-005 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  checking enable.
- ld  in  1  load strobe, as driven into the observed counter.
- ldvalue  in  WIDTH  load value, as driven into the observed counter.
- din  in  WIDTH  observed counter output.
- clr_err  in  1  clears error statistics.
- exp_val  out  WIDTH  expected counter value for the current cycle.
- tracking  out  1  high while in TRACK.
- mismatch  out  1  one-cycle pulse per detected error.
- err_cnt  out  ERR_W  saturating error total.
- first_bad  out  WIDTH  din value at the first error since clear.
- first_exp  out  WIDTH  exp_val at the first error since clear.
- resync  out  1  one-cycle pulse when RESYNC is entered.

Function
REQ-006 The checker SHALL model the counter: next = ld ? ldvalue : current + 1, modulo 2^WIDTH (wrap from all-ones to 0, no flag).
REQ-007 The FSM SHALL have the states IDLE, TRACK and RESYNC, all registered.
REQ-008 In IDLE, exp_val SHALL update each edge to ld ? ldvalue : din + 1, so that it follows the observed counter without comparing.
REQ-009 IDLE SHALL go to TRACK on any edge with en=1; the first comparison SHALL occur on the following edge.
REQ-010 In TRACK, each edge SHALL compare din with exp_val; inequality SHALL register mismatch=1 for exactly one cycle.
REQ-011 In TRACK, exp_val SHALL update to ld ? ldvalue : exp_val + 1 from its own model, never from din, including on mismatch cycles.
REQ-012 On each mismatch, err_cnt SHALL increment, saturating at 2^ERR_W-1 with no wrap.
REQ-013 On the first mismatch since reset or clr_err, first_bad and first_exp SHALL capture din and exp_val; later mismatches SHALL NOT overwrite them.
REQ-014 A consecutive-mismatch counter SHALL increment on a mismatch and clear on a match.
REQ-015 When that counter reaches RESYNC_N, the FSM SHALL enter RESYNC, pulse resync for one cycle, and clear the consecutive counter.
REQ-016 RESYNC SHALL last exactly one cycle: exp_val <= ld ? ldvalue : din + 1, no comparison is made, and the next state is TRACK (IDLE if en=0).
REQ-017 TRACK with en=0 SHALL go to IDLE on that edge, with no comparison on that edge.
REQ-018 When clr_err=1, err_cnt, first_bad, first_exp and the first-error flag SHALL clear; clr_err SHALL take priority over a same-edge mismatch increment, but the mismatch pulse SHALL still assert.
REQ-019 When ld=1 coincides with a mismatch, the compare SHALL use the pre-load exp_val, and exp_val SHALL load ldvalue.
REQ-020 tracking SHALL equal (state==TRACK) and be registered; mismatch and resync SHALL be registered with latency of one edge after the sampled din.

Reset
REQ-021 While rst=1 at an edge, the block SHALL go to IDLE with exp_val=0, tracking=0, mismatch=0, resync=0, err_cnt=0, first_bad=0, first_exp=0, and the consecutive count cleared.
REQ-022 rst SHALL override en, clr_err and ld; a reset mid-TRACK SHALL abandon any pending resync.

Verification
REQ-023 Reset then en=1, feed din as a correct counter from 0 for 20 cycles (wraps 15->0) -> mismatch never asserts, err_cnt=0.
REQ-024 In TRACK at exp_val=5, drive din=9 for one cycle -> mismatch pulses once, err_cnt=1, first_bad=9, first_exp=5, no resync.
REQ-025 Drive wrong din for 3 consecutive cycles -> 3 mismatch pulses, resync pulses, then correct din from the next cycle on produces no further errors.
REQ-026 ld=1, ldvalue=12 with a correct counter -> exp_val=12 next cycle, no error; apply ld at exp_val=15 -> load wins over wrap.
REQ-027 Force 300 mismatches with ERR_W=8 -> err_cnt holds 255; clr_err during a mismatch -> err_cnt=0, mismatch=1.
REQ-028 Assert rst during RESYNC with en=1 -> next cycle IDLE, all outputs 0, no resync pulse.

Source files
------------

// File: rtl/count_checker.sv
// Counter checker: predicts the next value of an observed up-counter with load
// and flags divergences, keeping error statistics and resyncing on error bursts.
//
// state  | meaning
// IDLE   | follow din (or the load value) without comparing
// TRACK  | compare din to the internal model every edge
// RESYNC | one-cycle re-seed of the model from din, no comparison
module count_checker #(
   parameter int WIDTH    = 4,
   parameter int ERR_W    = 8,
   parameter int RESYNC_N = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ld,
   input  logic [WIDTH-1:0] ldvalue,
   input  logic [WIDTH-1:0] din,
   input  logic             clr_err,
   output logic [WIDTH-1:0] exp_val,
   output logic             tracking,
   output logic             mismatch,
   output logic [ERR_W-1:0] err_cnt,
   output logic [WIDTH-1:0] first_bad,
   output logic [WIDTH-1:0] first_exp,
   output logic             resync
);

   localparam int CW = $clog2(RESYNC_N + 1);

   typedef enum logic [1:0] {IDLE, TRACK, RESYNC} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] exp_val_q;
   logic             tracking_q;
   logic             mismatch_q;
   logic [ERR_W-1:0] err_cnt_q;
   logic [WIDTH-1:0] first_bad_q;
   logic [WIDTH-1:0] first_exp_q;
   logic             first_seen_q;
   logic             resync_q;
   logic [CW-1:0]    consec_q;

   logic [WIDTH-1:0] follow_d;
   logic [WIDTH-1:0] model_d;
   logic [CW-1:0]    consec_d;
   logic             bad;
   logic             burst_done;

   // follow_d re-seeds from the observed counter; model_d advances our own copy
   assign follow_d   = ld ? ldvalue : din + 1'b1;
   assign model_d    = ld ? ldvalue : exp_val_q + 1'b1;
   assign bad        = (din != exp_val_q);
   assign consec_d   = consec_q + 1'b1;
   assign burst_done = (consec_d == CW'(RESYNC_N));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         exp_val_q    <= '0;
         tracking_q   <= 1'b0;
         mismatch_q   <= 1'b0;
         err_cnt_q    <= '0;
         first_bad_q  <= '0;
         first_exp_q  <= '0;
         first_seen_q <= 1'b0;
         resync_q     <= 1'b0;
         consec_q     <= '0;
      end else begin
         mismatch_q <= 1'b0;
         resync_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               exp_val_q <= follow_d;
               consec_q  <= '0;
               if (en) begin
                  state_q    <= TRACK;
                  tracking_q <= 1'b1;
               end
            end
            TRACK: begin
               exp_val_q <= model_d;
               if (!en) begin
                  state_q    <= IDLE;
                  tracking_q <= 1'b0;
                  consec_q   <= '0;
               end else if (bad) begin
                  mismatch_q <= 1'b1;
                  if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
                  if (!first_seen_q) begin
                     first_bad_q  <= din;
                     first_exp_q  <= exp_val_q;
                     first_seen_q <= 1'b1;
                  end
                  if (burst_done) begin
                     state_q    <= RESYNC;
                     tracking_q <= 1'b0;
                     resync_q   <= 1'b1;
                     consec_q   <= '0;
                  end else begin
                     consec_q <= consec_d;
                  end
               end else begin
                  consec_q <= '0;
               end
            end
            RESYNC: begin
               exp_val_q  <= follow_d;
               state_q    <= en ? TRACK : IDLE;
               tracking_q <= en;
            end
            default: begin
               state_q    <= IDLE;
               tracking_q <= 1'b0;
            end
         endcase
         // a clear overrides any same-edge statistics update; the pulse survives
         if (clr_err) begin
            err_cnt_q    <= '0;
            first_bad_q  <= '0;
            first_exp_q  <= '0;
            first_seen_q <= 1'b0;
         end
      end
   end

   assign exp_val   = exp_val_q;
   assign tracking  = tracking_q;
   assign mismatch  = mismatch_q;
   assign err_cnt   = err_cnt_q;
   assign first_bad = first_bad_q;
   assign first_exp = first_exp_q;
   assign resync    = resync_q;

endmodule

// File: tb/tb_count_checker.sv
// Randomized and directed bench for count_checker against a behavioural model
// of the checker's rules, compared on every cycle.
module tb_count_checker;

   logic       clk = 1'b0;
   logic       rst, en, ld, clr_err;
   logic [3:0] ldvalue, din;
   logic [3:0] exp_val, first_bad, first_exp;
   logic [7:0] err_cnt;
   logic       tracking, mismatch, resync;

   int n_vec = 0;
   int n_bad = 0;

   localparam int M_IDLE = 0, M_TRACK = 1, M_RESYNC = 2;
   int m_mode, m_exp, m_err, m_fb, m_fe, m_first, m_consec, m_mis, m_rs;
   int mis_total;

   always #5 clk = ~clk;

   count_checker #(.WIDTH(4), .ERR_W(8), .RESYNC_N(3)) dut (
      .clk(clk), .rst(rst), .en(en), .ld(ld), .ldvalue(ldvalue), .din(din),
      .clr_err(clr_err), .exp_val(exp_val), .tracking(tracking),
      .mismatch(mismatch), .err_cnt(err_cnt), .first_bad(first_bad),
      .first_exp(first_exp), .resync(resync)
   );

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // one step of the checker's rules, using the inputs that were present at the edge
   task automatic model_step(input int r, e, l, lv, d, c);
      if (r != 0) begin
         m_mode = M_IDLE; m_exp = 0; m_err = 0; m_fb = 0; m_fe = 0;
         m_first = 0; m_consec = 0; m_mis = 0; m_rs = 0;
         return;
      end
      m_mis = 0; m_rs = 0;
      if (m_mode == M_IDLE) begin
         m_exp = (l != 0) ? lv : (d + 1) % 16;
         m_consec = 0;
         m_mode = (e != 0) ? M_TRACK : M_IDLE;
      end else if (m_mode == M_RESYNC) begin
         m_exp = (l != 0) ? lv : (d + 1) % 16;
         m_mode = (e != 0) ? M_TRACK : M_IDLE;
      end else if (e == 0) begin
         m_exp = (l != 0) ? lv : (m_exp + 1) % 16;
         m_consec = 0;
         m_mode = M_IDLE;
      end else begin
         if (d != m_exp) begin
            m_mis = 1;
            mis_total++;
            if (m_err < 255) m_err++;
            if (m_first == 0) begin m_fb = d; m_fe = m_exp; m_first = 1; end
            m_consec++;
            if (m_consec == 3) begin m_mode = M_RESYNC; m_rs = 1; m_consec = 0; end
         end else begin
            m_consec = 0;
         end
         m_exp = (l != 0) ? lv : (m_exp + 1) % 16;
      end
      if (c != 0) begin m_err = 0; m_fb = 0; m_fe = 0; m_first = 0; end
   endtask

   task automatic cycle();
      int r, e, l, lv, d, c;
      r = rst; e = en; l = ld; lv = ldvalue; d = din; c = clr_err;
      @(posedge clk);
      model_step(r, e, l, lv, d, c);
      #1;
      chk("exp_val",   exp_val,   m_exp);
      chk("tracking",  tracking,  (m_mode == M_TRACK) ? 1 : 0);
      chk("mismatch",  mismatch,  m_mis);
      chk("err_cnt",   err_cnt,   m_err);
      chk("first_bad", first_bad, m_fb);
      chk("first_exp", first_exp, m_fe);
      chk("resync",    resync,    m_rs);
   endtask

   task automatic drive(input logic r, e, l, input logic [3:0] lv, d, input logic c);
      rst = r; en = e; ld = l; ldvalue = lv; din = d; clr_err = c;
      cycle();
   endtask

   function automatic logic [3:0] good();
      return 4'(m_exp);
   endfunction

   initial begin
      logic [3:0] cnt;
      int budget;
      mis_total = 0;
      m_mode = M_IDLE; m_exp = 0; m_err = 0; m_fb = 0; m_fe = 0;
      m_first = 0; m_consec = 0; m_mis = 0; m_rs = 0;
      rst = 1; en = 0; ld = 0; ldvalue = 0; din = 0; clr_err = 0;
      @(negedge clk);
      drive(1, 0, 0, 0, 7, 0);
      drive(1, 1, 1, 9, 3, 1);
      chk("reset exp_val", exp_val, 0);
      chk("reset tracking", tracking, 0);

      // correct counter from 0 for 20 cycles, wrapping 15->0
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         drive(0, 1, 0, 0, cnt, 0);
         cnt = cnt + 1'b1;
      end
      chk("clean run err_cnt", err_cnt, 0);
      chk("clean run tracking", tracking, 1);

      // single error at exp_val=5
      budget = 0;
      while (m_exp != 5 && budget < 40) begin drive(0, 1, 0, 0, good(), 0); budget++; end
      drive(0, 1, 0, 0, 4'd9, 0);
      chk("single mismatch", mismatch, 1);
      chk("single err_cnt", err_cnt, 1);
      chk("single first_bad", first_bad, 9);
      chk("single first_exp", first_exp, 5);
      chk("single resync", resync, 0);
      drive(0, 1, 0, 0, good(), 0);
      chk("single pulse width", mismatch, 0);

      // three consecutive errors force a resync, then clean again
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, good() ^ 4'd1, 0);
      chk("burst resync", resync, 1);
      chk("burst err_cnt", err_cnt, 4);
      for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, good(), 0);
      chk("post resync err_cnt", err_cnt, 4);
      chk("post resync first_bad", first_bad, 9);

      // load with a correct counter, and load winning over wrap
      drive(0, 1, 1, 4'd12, good(), 0);
      chk("load exp_val", exp_val, 12);
      budget = 0;
      while (m_exp != 15 && budget < 40) begin drive(0, 1, 0, 0, good(), 0); budget++; end
      drive(0, 1, 1, 4'd3, good(), 0);
      chk("load over wrap", exp_val, 3);
      chk("load no error", err_cnt, 4);

      // randomized phase
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(99) < 2), ($urandom_range(99) < 90),
               ($urandom_range(99) < 10), 4'($urandom_range(15)),
               ($urandom_range(99) < 80) ? good() : 4'($urandom_range(15)),
               ($urandom_range(99) < 3));
      end

      // saturation after 300 forced errors
      drive(0, 1, 0, 0, good(), 1);
      drive(0, 1, 0, 0, good(), 0);
      mis_total = 0;
      budget = 0;
      while (mis_total < 300 && budget < 2000) begin
         drive(0, 1, 0, 0, good() ^ 4'd5, 0);
         budget++;
      end
      chk("forced error budget", (mis_total >= 300) ? 1 : 0, 1);
      chk("saturated err_cnt", err_cnt, 255);
      budget = 0;
      while (m_mode != M_TRACK && budget < 5) begin drive(0, 1, 0, 0, good(), 0); budget++; end
      drive(0, 1, 0, 0, good() ^ 4'd2, 1);
      chk("clr with mismatch err_cnt", err_cnt, 0);
      chk("clr with mismatch pulse", mismatch, 1);
      chk("clr first_bad", first_bad, 0);

      // reset while in RESYNC
      for (int i = 0; i < 2; i++) drive(0, 1, 0, 0, good() ^ 4'd1, 0);
      chk("pre-reset resync", resync, 1);
      drive(1, 1, 1, 4'd7, 4'd3, 0);
      chk("rst in resync tracking", tracking, 0);
      chk("rst in resync resync", resync, 0);
      chk("rst in resync err_cnt", err_cnt, 0);
      chk("rst in resync exp_val", exp_val, 0);
      drive(0, 1, 0, 0, 4'd3, 0);
      chk("after reset resync", resync, 0);
      chk("after reset exp_val", exp_val, 4);
      for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, good(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
